// File: rtl/regfile_mt_if.sv
// Register-file access bundle: shared read request, two write ports and the status outputs.
// The master side is issue/writeback/LSU; the slave side is the register file.
interface regfile_mt_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HART_ID_W  = 2,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  init_done;
    logic                  r_en;
    logic [HART_ID_W-1:0]  r_hart_id;
    logic [REG_ADDR_W-1:0] raddr1;
    logic [REG_ADDR_W-1:0] raddr2;
    logic [XLEN-1:0]       rdata1;
    logic [XLEN-1:0]       rdata2;
    logic                  w0_en;
    logic [HART_ID_W-1:0]  w0_hart_id;
    logic [REG_ADDR_W-1:0] w0_addr;
    logic [XLEN-1:0]       w0_data;
    logic                  w1_en;
    logic [HART_ID_W-1:0]  w1_hart_id;
    logic [REG_ADDR_W-1:0] w1_addr;
    logic [XLEN-1:0]       w1_data;
    logic                  w_conflict;

    modport master (
        input  init_done, rdata1, rdata2, w_conflict,
        output r_en, r_hart_id, raddr1, raddr2,
        output w0_en, w0_hart_id, w0_addr, w0_data,
        output w1_en, w1_hart_id, w1_addr, w1_data
    );

    modport slave (
        output init_done, rdata1, rdata2, w_conflict,
        input  r_en, r_hart_id, raddr1, raddr2,
        input  w0_en, w0_hart_id, w0_addr, w0_data,
        input  w1_en, w1_hart_id, w1_addr, w1_data
    );
endinterface

// File: rtl/regfile_mt.sv
// Multi-hart integer register file: 2 registered read ports with write bypass, 2 write ports.
// Storage has no reset; a post-reset sweep clears one entry per cycle before accepting traffic.
module regfile_mt #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_HARTS  = 4,
    parameter int unsigned HART_ID_W  = $clog2(NUM_HARTS),
    parameter int unsigned REG_ADDR_W = 5
) (
    input logic         clk_i,
    input logic         rst_i,
    regfile_mt_if.slave bus
);
    localparam int unsigned EntryW     = HART_ID_W + REG_ADDR_W;
    localparam int unsigned NumEntries = 1 << EntryW;

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e              state_q, state_d;
    logic [EntryW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]     mem_q [NumEntries];
    logic [XLEN-1:0]     rd_q [2];
    logic [XLEN-1:0]     rd_d [2];
    logic                conflict_q, conflict_d;

    logic                ready;
    logic                w0_ok, w1_ok, w0_commit;
    logic [EntryW-1:0]   w0_idx, w1_idx;
    logic [EntryW-1:0]   r_idx [2];
    logic [REG_ADDR_W-1:0] r_addr [2];

    assign ready     = (state_q == StReady);
    assign w0_idx    = {bus.w0_hart_id, bus.w0_addr};
    assign w1_idx    = {bus.w1_hart_id, bus.w1_addr};
    // x0 writes are dropped at the port so they can never clobber the swept zero
    assign w0_ok     = ready && !rst_i && bus.w0_en && (bus.w0_addr != '0);
    assign w1_ok     = ready && !rst_i && bus.w1_en && (bus.w1_addr != '0);
    assign w0_commit = w0_ok && !(w1_ok && (w0_idx == w1_idx));
    assign conflict_d = w0_ok && w1_ok && (w0_idx == w1_idx);

    assign r_addr[0] = bus.raddr1;
    assign r_addr[1] = bus.raddr2;
    assign r_idx[0]  = {bus.r_hart_id, bus.raddr1};
    assign r_idx[1]  = {bus.r_hart_id, bus.raddr2};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == EntryW'(NumEntries - 1)) state_d = StReady;
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
            rd_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!ready) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (w0_commit) mem_q[w0_idx] <= bus.w0_data;
            if (w1_ok)     mem_q[w1_idx] <= bus.w1_data;
        end
    end

    // Bypass priority mirrors commit priority: w1 over w0 over array
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = rd_q[p];
            if (ready && bus.r_en) begin
                if (r_addr[p] == '0) begin
                    rd_d[p] = '0;
                end else if (w1_ok && (w1_idx == r_idx[p])) begin
                    rd_d[p] = bus.w1_data;
                end else if (w0_ok && (w0_idx == r_idx[p])) begin
                    rd_d[p] = bus.w0_data;
                end else begin
                    rd_d[p] = mem_q[r_idx[p]];
                end
            end
        end
    end

    assign bus.init_done  = ready;
    assign bus.rdata1     = rd_q[0];
    assign bus.rdata2     = rd_q[1];
    assign bus.w_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_mt.sv
// Directed bench for regfile_mt: reset sweep, isolation, x0, bypass/conflict, INIT drops, re-reset.
module tb_regfile_mt;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   lows;

    always #5 clk = ~clk;

    regfile_mt_if #(.XLEN(32), .HART_ID_W(2), .REG_ADDR_W(5)) bus ();

    regfile_mt #(.XLEN(32), .NUM_HARTS(4), .HART_ID_W(2), .REG_ADDR_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.r_en  = 1'b0;
        bus.w0_en = 1'b0;
        bus.w1_en = 1'b0;
    endtask

    task automatic wr0(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
        bus.w0_en = 1'b1; bus.w0_hart_id = h; bus.w0_addr = a; bus.w0_data = d;
    endtask

    task automatic wr1(input logic [1:0] h, input logic [4:0] a, input logic [31:0] d);
        bus.w1_en = 1'b1; bus.w1_hart_id = h; bus.w1_addr = a; bus.w1_data = d;
    endtask

    task automatic rd(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
        bus.r_en = 1'b1; bus.r_hart_id = h; bus.raddr1 = a1; bus.raddr2 = a2;
    endtask

    // Count sampled low cycles of init_done; optionally inject dropped writes during the sweep
    task automatic wait_init(input bit inject, output int n);
        n = 0;
        while (!bus.init_done && n < 200) begin
            if (inject && n == 10) begin
                wr0(2'd0, 5'd3, 32'hAA);
                wr1(2'd0, 5'd3, 32'hBB);
                rd(2'd0, 5'd3, 5'd3);
            end
            if (inject && n == 11) chk("conflict_in_init", {31'd0, bus.w_conflict}, 32'd0);
            step();
            idle();
            n++;
        end
    endtask

    initial begin
        idle();
        bus.r_hart_id = '0; bus.raddr1 = '0; bus.raddr2 = '0;
        bus.w0_hart_id = '0; bus.w0_addr = '0; bus.w0_data = '0;
        bus.w1_hart_id = '0; bus.w1_addr = '0; bus.w1_data = '0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        chk("rst_rdata2", bus.rdata2, 32'd0);
        chk("rst_conflict", {31'd0, bus.w_conflict}, 32'd0);

        wait_init(1'b1, lows);
        chk("sweep_len", lows, 32'd128);
        chk("init_done_high", {31'd0, bus.init_done}, 32'd1);

        for (int h = 0; h < 4; h++) begin
            for (int r = 0; r < 32; r++) begin
                rd(2'(h), 5'(r), 5'(31 - r));
                step();
                idle();
                chk($sformatf("clear_h%0d_r%0d", h, r), bus.rdata1, 32'd0);
                chk($sformatf("clear_h%0d_r%0d", h, 31 - r), bus.rdata2, 32'd0);
            end
        end

        rd(2'd0, 5'd3, 5'd0);
        step(); idle();
        chk("init_write_dropped", bus.rdata1, 32'd0);

        // Basic write and hart isolation
        wr0(2'd2, 5'd5, 32'hDEADBEEF);
        step(); idle();
        rd(2'd2, 5'd5, 5'd5);
        step(); idle();
        chk("h2_x5_p1", bus.rdata1, 32'hDEADBEEF);
        chk("h2_x5_p2", bus.rdata2, 32'hDEADBEEF);
        for (int h = 0; h < 4; h++) begin
            if (h != 2) begin
                rd(2'(h), 5'd5, 5'd5);
                step(); idle();
                chk($sformatf("iso_h%0d_x5", h), bus.rdata1, 32'd0);
            end
        end

        // x0 stays zero, no conflict
        wr1(2'd1, 5'd0, 32'h12345678);
        step(); idle();
        chk("x0_no_conflict", {31'd0, bus.w_conflict}, 32'd0);
        rd(2'd1, 5'd0, 5'd0);
        step(); idle();
        chk("x0_rd1", bus.rdata1, 32'd0);
        chk("x0_rd2", bus.rdata2, 32'd0);

        // Distinct entries on both ports both commit
        wr0(2'd0, 5'd8, 32'h11);
        wr1(2'd0, 5'd9, 32'h22);
        step(); idle();
        chk("dual_no_conflict", {31'd0, bus.w_conflict}, 32'd0);
        rd(2'd0, 5'd8, 5'd9);
        step(); idle();
        chk("dual_x8", bus.rdata1, 32'h11);
        chk("dual_x9", bus.rdata2, 32'h22);

        // Same-entry conflict with bypassed read
        wr0(2'd0, 5'd7, 32'h1);
        wr1(2'd0, 5'd7, 32'h2);
        rd(2'd0, 5'd7, 5'd8);
        step(); idle();
        chk("bypass_w1", bus.rdata1, 32'h2);
        chk("array_x8", bus.rdata2, 32'h11);
        chk("conflict_pulse", {31'd0, bus.w_conflict}, 32'd1);
        step();
        chk("conflict_clear", {31'd0, bus.w_conflict}, 32'd0);
        rd(2'd0, 5'd7, 5'd7);
        step(); idle();
        chk("x7_after", bus.rdata1, 32'h2);

        // w0-only bypass; concurrent write to another hart must not leak
        wr0(2'd1, 5'd4, 32'hCAFE);
        wr1(2'd3, 5'd4, 32'hF00D);
        rd(2'd1, 5'd4, 5'd9);
        step(); idle();
        chk("bypass_w0", bus.rdata1, 32'hCAFE);
        chk("h1_x9_zero", bus.rdata2, 32'd0);

        // r_en low holds
        bus.raddr1 = 5'd7; bus.raddr2 = 5'd8; bus.r_hart_id = 2'd0;
        step();
        chk("hold_rd1", bus.rdata1, 32'hCAFE);
        chk("hold_rd2", bus.rdata2, 32'd0);

        // Mid-operation reset
        wr0(2'd3, 5'd31, 32'h55);
        step(); idle();
        rd(2'd3, 5'd31, 5'd4);
        step(); idle();
        chk("h3_x31", bus.rdata1, 32'h55);
        chk("h3_x4", bus.rdata2, 32'hF00D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rerst_rd1", bus.rdata1, 32'd0);
        chk("rerst_rd2", bus.rdata2, 32'd0);
        chk("rerst_init_done", {31'd0, bus.init_done}, 32'd0);
        wait_init(1'b0, lows);
        chk("resweep_len", lows, 32'd128);
        rd(2'd3, 5'd31, 5'd4);
        step(); idle();
        chk("resweep_x31", bus.rdata1, 32'd0);
        chk("resweep_x4", bus.rdata2, 32'd0);
        rd(2'd2, 5'd5, 5'd0);
        step(); idle();
        chk("resweep_h2_x5", bus.rdata1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
